// File: rtl/branch_cond_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : branch_cond_unit                                             |
// | Description : Captures the ALU NZVC flags into a condition-code register.  |
// |               On an accepted branch request, evaluates the branch opcode   |
// |               against the CCR and drives the PC with the target or the    |
// |               skip address.                                                |
// | Options     : BRANCH_STATS_EN adds an 8-bit saturating taken_count output. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module branch_cond_unit #(
  parameter int ADDR_W     = 8,
  parameter int SKIP_BYTES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        nzvc_in,
  input  logic              ccr_load,
  input  logic              br_req,
  input  logic [3:0]        br_op,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              br_busy,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_out,
  output logic              taken,
  output logic              br_done,
`ifdef BRANCH_STATS_EN
  output logic [7:0]        taken_count,
`endif
  output logic [3:0]        ccr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  // Skip increment reduced to the address width so the add wraps naturally.
  localparam logic [ADDR_W-1:0] c_SKIP = ADDR_W'(SKIP_BYTES);

  state_t              state_q, state_d;
  logic [3:0]          ccr_q, ccr_d;
  logic [3:0]          op_q, op_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
  logic                taken_q, taken_d;
  logic                w_cond;

  // Branch condition table; flags are {N,Z,V,C}.
  function automatic logic f_cond(input logic [3:0] op, input logic [3:0] f);
    logic n, z, v, c;
    n = f[3];
    z = f[2];
    v = f[1];
    c = f[0];
    case (op)
      4'h0:    f_cond = 1'b1;
      4'h1:    f_cond = z;
      4'h2:    f_cond = !z;
      4'h3:    f_cond = n;
      4'h4:    f_cond = !n;
      4'h5:    f_cond = v;
      4'h6:    f_cond = !v;
      4'h7:    f_cond = c;
      4'h8:    f_cond = !c;
      4'h9:    f_cond = !c && !z;
      4'hA:    f_cond = c || z;
      4'hB:    f_cond = (n == v);
      4'hC:    f_cond = (n != v);
      4'hD:    f_cond = !z && (n == v);
      4'hE:    f_cond = z || (n != v);
      default: f_cond = 1'b0;
    endcase
  endfunction

  // Decision always uses the registered CCR, so a load during EVAL lands too late.
  always_comb w_cond = f_cond(op_q, ccr_q);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: CCR, latched request fields and the registered decision.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ccr_q    <= 4'b0000;
      op_q     <= 4'h0;
      tgt_q    <= '0;
      pc_q     <= '0;
      pc_out_q <= '0;
      taken_q  <= 1'b0;
    end else begin
      ccr_q    <= ccr_d;
      op_q     <= op_d;
      tgt_q    <= tgt_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      taken_q  <= taken_d;
    end
  end

  // Next-state, next-datapath and strobe outputs.
  always_comb begin
    state_d  = state_q;
    ccr_d    = ccr_load ? nzvc_in : ccr_q;
    op_d     = op_q;
    tgt_d    = tgt_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    taken_d  = taken_q;
    br_busy  = 1'b0;
    pc_load  = 1'b0;
    br_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (br_req) begin
          op_d    = br_op;
          tgt_d   = target;
          pc_d    = pc_in;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        br_busy  = 1'b1;
        taken_d  = w_cond;
        pc_out_d = w_cond ? tgt_q : (pc_q + c_SKIP);
        state_d  = ST_UPDATE;
      end
      ST_UPDATE: begin
        br_busy = 1'b1;
        pc_load = 1'b1;
        br_done = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pc_out = pc_out_q;
  assign taken  = taken_q;
  assign ccr    = ccr_q;

`ifdef BRANCH_STATS_EN
  logic [7:0] cnt_q;

  // Saturating count of taken branches, counted at the PC update.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= 8'h00;
    end else if ((state_q == ST_UPDATE) && taken_q && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign taken_count = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_cond_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_branch_cond_unit                                          |
// | Description : Self-checking bench for branch_cond_unit with a scoreboard   |
// |               of expected {br_done, taken, pc_out} per PC update.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_branch_cond_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] nzvc_in;
  logic       ccr_load;
  logic       br_req;
  logic [3:0] br_op;
  logic [7:0] target;
  logic [7:0] pc_in;
  logic       br_busy;
  logic       pc_load;
  logic [7:0] pc_out;
  logic       taken;
  logic       br_done;
  logic [3:0] ccr;
`ifdef BRANCH_STATS_EN
  logic [7:0] taken_count;
`endif

  branch_cond_unit #(.ADDR_W(8), .SKIP_BYTES(1)) dut (
    .clock    (clock),
    .reset    (reset),
    .nzvc_in  (nzvc_in),
    .ccr_load (ccr_load),
    .br_req   (br_req),
    .br_op    (br_op),
    .target   (target),
    .pc_in    (pc_in),
    .br_busy  (br_busy),
    .pc_load  (pc_load),
    .pc_out   (pc_out),
    .taken    (taken),
    .br_done  (br_done),
`ifdef BRANCH_STATS_EN
    .taken_count (taken_count),
`endif
    .ccr      (ccr)
  );

  always #5 clock = ~clock;

  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  logic [3:0] m_ccr;
  int         n_checks = 0;
  int         n_fails  = 0;

  // Reference branch table written as independent boolean algebra.
  function automatic logic m_cond(input logic [3:0] op, input logic [3:0] f);
    logic n, z, v, c;
    {n, z, v, c} = f;
    case (op)
      4'h0: return 1'b1;
      4'h1: return z;
      4'h2: return ~z;
      4'h3: return n;
      4'h4: return ~n;
      4'h5: return v;
      4'h6: return ~v;
      4'h7: return c;
      4'h8: return ~c;
      4'h9: return ~(c | z);
      4'hA: return c | z;
      4'hB: return ~(n ^ v);
      4'hC: return n ^ v;
      4'hD: return ~(z | (n ^ v));
      4'hE: return z | (n ^ v);
      default: return 1'b0;
    endcase
  endfunction

  // Advance one clock and record any PC update the DUT produces.
  task automatic tick();
    @(posedge clock);
    #1;
    if (pc_load) obs_q.push_back({br_done, taken, pc_out});
  endtask

  // Present a request for one edge (DUT must be idle) and log its expected result.
  task automatic issue(input logic [3:0] op, input logic [7:0] tgt, input logic [7:0] pc);
    logic       t;
    logic [7:0] skip;
    skip   = pc + 8'd1;
    t      = m_cond(op, m_ccr);
    exp_q.push_back({1'b1, t, (t ? tgt : skip)});
    br_op  = op;
    target = tgt;
    pc_in  = pc;
    br_req = 1'b1;
    tick();
    br_req = 1'b0;
  endtask

  task automatic load_ccr(input logic [3:0] f);
    nzvc_in  = f;
    ccr_load = 1'b1;
    tick();
    ccr_load = 1'b0;
    m_ccr    = f;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    reset = 1'b0;
    tick();
    tick();
    obs = {br_busy, pc_load, br_done, taken, ccr, 2'b00};
    n_checks++;
    if (obs !== 10'b0 || pc_out !== 8'h00) begin
      n_fails++;
      $display("FAIL reset_state: got busy/load/done/taken/ccr=%b pc_out=%h, required all zero", obs, pc_out);
    end
    reset = 1'b1;
    m_ccr = 4'h0;
    // Abort a branch in EVAL with reset.
    load_ccr(4'hF);
    br_op = 4'h0; target = 8'h33; pc_in = 8'h20; br_req = 1'b1;
    tick();
    br_req = 1'b0;
    n_checks++;
    if (br_busy !== 1'b1) begin
      n_fails++;
      $display("FAIL abort_in_eval: br_busy=%b, required 1", br_busy);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_ccr = 4'h0;
    n_checks++;
    if (br_busy !== 1'b0 || ccr !== 4'h0 || pc_load !== 1'b0) begin
      n_fails++;
      $display("FAIL abort_reset: busy=%b ccr=%h pc_load=%b, required 0 0 0", br_busy, ccr, pc_load);
    end
    repeat (4) tick();
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fails++;
      $display("FAIL abort_no_done: %0d pc updates seen, required 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_beq_taken();
    logic [9:0] e, o;
    load_ccr(4'b0100);
    issue(4'h1, 8'h40, 8'h10);
    n_checks++;
    if (pc_load !== 1'b0 || br_busy !== 1'b1) begin
      n_fails++;
      $display("FAIL beq_eval_phase: pc_load=%b busy=%b, required 0 1", pc_load, br_busy);
    end
    tick();
    n_checks++;
    if (pc_load !== 1'b1) begin
      n_fails++;
      $display("FAIL beq_latency: pc_load=%b two edges after accept, required 1", pc_load);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fails++;
        $display("FAIL beq_sb: no pc update, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fails++;
          $display("FAIL beq_sb: got %h, required %h", o, e);
        end
      end
    end
    tick();
    n_checks++;
    if (pc_load !== 1'b0 || br_busy !== 1'b0 || pc_out !== 8'h40) begin
      n_fails++;
      $display("FAIL beq_after: pc_load=%b busy=%b pc_out=%h, required 0 0 40", pc_load, br_busy, pc_out);
    end
  endtask

  task automatic test_wrap();
    logic [9:0] e, o;
    load_ccr(4'b0000);
    issue(4'h1, 8'h55, 8'hFF);
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fails++;
        $display("FAIL wrap_sb: no pc update, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fails++;
          $display("FAIL wrap_sb: got %h, required %h", o, e);
        end
      end
    end
    tick();
    n_checks++;
    if (br_done !== 1'b0 || pc_out !== 8'h00 || taken !== 1'b0) begin
      n_fails++;
      $display("FAIL wrap_after: br_done=%b pc_out=%h taken=%b, required 0 00 0", br_done, pc_out, taken);
    end
  endtask

  task automatic test_opcodes();
    logic [9:0] e, o;
    int         bad;
    bad = 0;
    for (int f = 0; f < 16; f++) begin
      for (int op = 0; op < 16; op++) begin
        load_ccr(4'(f));
        issue(4'(op), {4'(op), 4'(f)}, ~{4'(op), 4'(f)});
        tick();
      end
    end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fails++;
        $display("FAIL opcode_sb: no pc update, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fails++;
          bad++;
          if (bad < 10) $display("FAIL opcode_sb: got %h, required %h", o, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e, o;
    logic [5:0] busy_seq, load_seq;
    logic       t;
    busy_seq = '0;
    load_seq = '0;
    load_ccr(4'b0001);
    t = m_cond(4'h7, m_ccr);
    exp_q.push_back({1'b1, t, 8'hA0});
    exp_q.push_back({1'b1, t, 8'hB0});
    br_op = 4'h7; target = 8'hA0; pc_in = 8'h60; br_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      busy_seq[5-i] = br_busy;
      load_seq[5-i] = pc_load;
      target = 8'hB0;
    end
    br_req = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (busy_seq !== 6'b110110 || load_seq !== 6'b010010) begin
      n_fails++;
      $display("FAIL b2b_sequence: busy=%b load=%b, required 110110 010010", busy_seq, load_seq);
    end
    n_checks++;
    if (obs_q.size() != 2) begin
      n_fails++;
      $display("FAIL b2b_count: %0d evaluations, required 2", obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fails++;
        $display("FAIL b2b_sb: no pc update, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fails++;
          $display("FAIL b2b_sb: got %h, required %h", o, e);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_ccr_timing();
    logic [9:0] e, o;
    load_ccr(4'b0000);
    // CCR load in the accept cycle is seen by the decision.
    nzvc_in  = 4'b1000;
    ccr_load = 1'b1;
    m_ccr    = 4'b1000;
    issue(4'hC, 8'h77, 8'h30);
    // CCR load during EVAL is not seen by the decision.
    nzvc_in  = 4'b0000;
    ccr_load = 1'b1;
    tick();
    ccr_load = 1'b0;
    m_ccr    = 4'b0000;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fails++;
        $display("FAIL ccr_timing_sb: no pc update, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e || o[8] !== 1'b1) begin
          n_fails++;
          $display("FAIL ccr_timing_sb: got %h, required %h", o, e);
        end
      end
    end
    n_checks++;
    if (ccr !== 4'b0000) begin
      n_fails++;
      $display("FAIL ccr_eval_load: ccr=%b, required 0000", ccr);
    end
    tick();
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    logic [9:0] e, o;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_ccr = 4'h0;
    exp_q.delete();
    obs_q.delete();
    n_checks++;
    if (taken_count !== 8'h00) begin
      n_fails++;
      $display("FAIL stats_reset: taken_count=%h, required 00", taken_count);
    end
    issue(4'h0, 8'h11, 8'h01);
    repeat (2) tick();
    issue(4'hF, 8'h11, 8'h01);
    repeat (2) tick();
    n_checks++;
    if (taken_count !== 8'h01) begin
      n_fails++;
      $display("FAIL stats_not_taken: taken_count=%h, required 01", taken_count);
    end
    for (int i = 0; i < 299; i++) begin
      issue(4'h0, 8'(i), 8'h02);
      repeat (2) tick();
    end
    n_checks++;
    if (taken_count !== 8'hFF) begin
      n_fails++;
      $display("FAIL stats_saturate: taken_count=%h, required FF", taken_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fails++;
        $display("FAIL stats_sb: no pc update, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fails++;
          $display("FAIL stats_sb: got %h, required %h", o, e);
        end
      end
    end
  endtask
`endif

  initial begin
    reset    = 1'b0;
    nzvc_in  = 4'h0;
    ccr_load = 1'b0;
    br_req   = 1'b0;
    br_op    = 4'h0;
    target   = 8'h00;
    pc_in    = 8'h00;
    m_ccr    = 4'h0;
    test_reset();
    test_beq_taken();
    test_wrap();
    test_opcodes();
    test_back_to_back();
    test_ccr_timing();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
